// File: rtl/rs_pkg.sv
// Shared constants and helpers for the reservation-station slot manager.
//   idx_w(n)        : index width for an n-entry structure
//   RS_ALU_ENTRIES  : entry count of the ALU station
//   RS_BR_ENTRIES   : entry count of the branch station
package rs_pkg;

    localparam int RS_ALU_ENTRIES = 6;
    localparam int RS_BR_ENTRIES  = 3;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rs_slot_alloc_if.sv
// Dispatch / issue bus of one reservation station.
//   master : core side (drives rdy, flush, alloc_*, wake_mask, issue_ack)
//   slave  : rs_slot_alloc (drives free_*, issue_*, free_cnt)
interface rs_slot_alloc_if
    import rs_pkg::*;
#(
    parameter int ENTRIES = RS_ALU_ENTRIES
);
    localparam int IDX_W = idx_w(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    logic               rdy;
    logic               flush;
    logic               free_vld_1;
    logic               free_vld_2;
    logic [IDX_W-1:0]   free_idx_1;
    logic [IDX_W-1:0]   free_idx_2;
    logic               alloc_1;
    logic               alloc_2;
    logic               alloc_rdy_1;
    logic               alloc_rdy_2;
    logic [ENTRIES-1:0] wake_mask;
    logic               issue_vld;
    logic [IDX_W-1:0]   issue_idx;
    logic               issue_ack;
    logic [CNT_W-1:0]   free_cnt;

    modport master (
        output rdy, flush, alloc_1, alloc_2, alloc_rdy_1, alloc_rdy_2,
               wake_mask, issue_ack,
        input  free_vld_1, free_vld_2, free_idx_1, free_idx_2,
               issue_vld, issue_idx, free_cnt
    );

    modport slave (
        input  rdy, flush, alloc_1, alloc_2, alloc_rdy_1, alloc_rdy_2,
               wake_mask, issue_ack,
        output free_vld_1, free_vld_2, free_idx_1, free_idx_2,
               issue_vld, issue_idx, free_cnt
    );

endinterface

// File: rtl/rs_prio_enc.sv
// First / second set-bit finder.
//   vec                    : input vector
//   first_vld, first_idx   : lowest set bit (idx 0 when none)
//   second_vld, second_idx : next set bit above it (idx 0 when none)
module rs_prio_enc
    import rs_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [N-1:0]          vec,
    output logic                  first_vld,
    output logic [idx_w(N)-1:0]   first_idx,
    output logic                  second_vld,
    output logic [idx_w(N)-1:0]   second_idx
);
    localparam int W = idx_w(N);

    always_comb begin
        first_vld  = 1'b0;
        first_idx  = '0;
        second_vld = 1'b0;
        second_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                if (!first_vld) begin
                    first_vld = 1'b1;
                    first_idx = W'(i);
                end else if (!second_vld) begin
                    second_vld = 1'b1;
                    second_idx = W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/rs_slot_alloc.sv
// Reservation-station slot manager: tracks busy/ready per entry, offers the
// two lowest free slots to dispatch, selects one ready entry for issue.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rs_slot_alloc_if.slave (dispatch, wakeup, issue, flush, rdy)
// Build option RS_AGE_SELECT_EN: issue picks the oldest ready entry using an
// ENTRIES x ENTRIES age matrix; otherwise the lowest-index ready entry.
// All outputs depend on registered state only.
module rs_slot_alloc
    import rs_pkg::*;
#(
    parameter int ENTRIES = RS_ALU_ENTRIES
) (
    input  logic           clk,
    input  logic           rst,
    rs_slot_alloc_if.slave bus
);
    localparam int IDX_W = idx_w(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    logic [ENTRIES-1:0] busy_q, busy_d, ready_q, ready_d;
    logic [ENTRIES-1:0] cand;
    logic               a1_fire, a2_fire, issue_fire;

    rs_prio_enc #(.N(ENTRIES)) u_free_enc (
        .vec        (~busy_q),
        .first_vld  (bus.free_vld_1),
        .first_idx  (bus.free_idx_1),
        .second_vld (bus.free_vld_2),
        .second_idx (bus.free_idx_2)
    );

    assign cand = busy_q & ready_q;

`ifdef RS_AGE_SELECT_EN
    // age_q[j][i] set: entry j is older than entry i.
    logic [ENTRIES-1:0][ENTRIES-1:0] age_q, age_d;
    logic [ENTRIES-1:0]              oldest;

    always_comb begin
        oldest        = '0;
        bus.issue_vld = |cand;
        bus.issue_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            oldest[i] = cand[i];
            for (int j = 0; j < ENTRIES; j++)
                if (j != i && cand[j] && age_q[j][i]) oldest[i] = 1'b0;
        end
        for (int i = 0; i < ENTRIES; i++)
            if (oldest[i]) bus.issue_idx = IDX_W'(i);
    end

    // A new entry is younger than everything already busy; on a dual
    // allocation the second slot is also younger than the first.
    always_comb begin
        age_d = age_q;
        if (bus.flush) begin
            age_d = '0;
        end else if (bus.rdy) begin
            if (a1_fire) begin
                for (int j = 0; j < ENTRIES; j++) age_d[bus.free_idx_1][j] = 1'b0;
                for (int j = 0; j < ENTRIES; j++) age_d[j][bus.free_idx_1] = busy_q[j];
            end
            if (a2_fire) begin
                for (int j = 0; j < ENTRIES; j++) age_d[bus.free_idx_2][j] = 1'b0;
                for (int j = 0; j < ENTRIES; j++)
                    age_d[j][bus.free_idx_2] = busy_q[j] || (IDX_W'(j) == bus.free_idx_1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) age_q <= '0;
        else     age_q <= age_d;
    end
`else
    logic             unused_issue_vld2;
    logic [IDX_W-1:0] unused_issue_idx2;

    rs_prio_enc #(.N(ENTRIES)) u_issue_enc (
        .vec        (cand),
        .first_vld  (bus.issue_vld),
        .first_idx  (bus.issue_idx),
        .second_vld (unused_issue_vld2),
        .second_idx (unused_issue_idx2)
    );
`endif

    assign a1_fire    = bus.alloc_1 && bus.free_vld_1;
    assign a2_fire    = bus.alloc_1 && bus.alloc_2 && bus.free_vld_2;
    assign issue_fire = bus.issue_ack && bus.issue_vld;

    // Offered slots are never busy, so issue-clear and allocate-set cannot
    // target the same entry; wakeup is folded into the allocate write.
    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        if (bus.flush) begin
            busy_d  = '0;
            ready_d = '0;
        end else if (bus.rdy) begin
            ready_d = ready_q | (bus.wake_mask & busy_q);
            if (issue_fire) begin
                busy_d[bus.issue_idx]  = 1'b0;
                ready_d[bus.issue_idx] = 1'b0;
            end
            if (a1_fire) begin
                busy_d[bus.free_idx_1]  = 1'b1;
                ready_d[bus.free_idx_1] = bus.alloc_rdy_1 | bus.wake_mask[bus.free_idx_1];
            end
            if (a2_fire) begin
                busy_d[bus.free_idx_2]  = 1'b1;
                ready_d[bus.free_idx_2] = bus.alloc_rdy_2 | bus.wake_mask[bus.free_idx_2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            ready_q <= '0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        bus.free_cnt = CNT_W'(ENTRIES);
        for (int i = 0; i < ENTRIES; i++)
            bus.free_cnt = bus.free_cnt - CNT_W'(busy_q[i]);
    end

endmodule

// File: tb/tb_rs_slot_alloc.sv
// Directed scoreboard bench for rs_slot_alloc (ENTRIES=6). The stimulus
// process queues the output snapshot expected after each edge; the monitor
// compares it on the following falling edge.
module tb_rs_slot_alloc;

    localparam int ENTRIES = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rs_slot_alloc_if #(.ENTRIES(ENTRIES)) bus ();

    rs_slot_alloc #(.ENTRIES(ENTRIES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int cyc;
        int fv1, fi1, fv2, fi2, iv, ii, fc;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            me = sb.pop_front();
            if (me.cyc < cyc) begin
                chk("missed_sample", cyc, me.cyc);
            end else begin
                chk("free_vld_1", int'(bus.free_vld_1), me.fv1);
                chk("free_idx_1", int'(bus.free_idx_1), me.fi1);
                chk("free_vld_2", int'(bus.free_vld_2), me.fv2);
                chk("free_idx_2", int'(bus.free_idx_2), me.fi2);
                chk("issue_vld",  int'(bus.issue_vld),  me.iv);
                chk("issue_idx",  int'(bus.issue_idx),  me.ii);
                chk("free_cnt",   int'(bus.free_cnt),   me.fc);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic r, input logic rd, input logic fl,
                        input logic a1, input logic ar1, input logic a2, input logic ar2,
                        input logic [ENTRIES-1:0] wk, input logic ack,
                        input int fv1, input int fi1, input int fv2, input int fi2,
                        input int iv, input int ii, input int fc);
        exp_t e;
        rst             = r;
        bus.rdy         = rd;
        bus.flush       = fl;
        bus.alloc_1     = a1;
        bus.alloc_rdy_1 = ar1;
        bus.alloc_2     = a2;
        bus.alloc_rdy_2 = ar2;
        bus.wake_mask   = wk;
        bus.issue_ack   = ack;
        e.cyc = cyc + 1;
        e.fv1 = fv1; e.fi1 = fi1; e.fv2 = fv2; e.fi2 = fi2;
        e.iv = iv; e.ii = ii; e.fc = fc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.rdy = 1'b1; bus.flush = 1'b0;
        bus.alloc_1 = 1'b0; bus.alloc_2 = 1'b0;
        bus.alloc_rdy_1 = 1'b0; bus.alloc_rdy_2 = 1'b0;
        bus.wake_mask = '0; bus.issue_ack = 1'b0;
        @(posedge clk);
        #1;
        //   rst rdy fl  a1 ar1 a2 ar2 wake      ack  fv1 fi1 fv2 fi2 iv ii fc
        step(1, 1, 0,  0, 0, 0, 0, 6'b000000, 0,   1, 0, 1, 1,  0, 0, 6); // reset
        step(0, 1, 0,  1, 0, 1, 0, 6'b000000, 0,   1, 2, 1, 3,  0, 0, 4); // alloc 0,1
        step(0, 1, 0,  1, 0, 1, 0, 6'b000000, 0,   1, 4, 1, 5,  0, 0, 2); // alloc 2,3
        step(0, 1, 0,  1, 0, 1, 0, 6'b000000, 0,   0, 0, 0, 0,  0, 0, 0); // alloc 4,5 full
        step(0, 1, 0,  0, 0, 0, 0, 6'b000100, 0,   0, 0, 0, 0,  1, 2, 0); // wake 2
        step(0, 1, 0,  0, 0, 0, 0, 6'b000000, 1,   1, 2, 0, 0,  0, 0, 1); // issue 2
        // ack without issue_vld ignored; alloc_2 ignored with one free slot
        step(0, 1, 0,  1, 0, 1, 1, 6'b000000, 1,   0, 0, 0, 0,  0, 0, 0);
        // flush beats alloc, wake and ack
        step(0, 1, 1,  1, 1, 1, 1, 6'b111111, 1,   1, 0, 1, 1,  0, 0, 6);
        // same-cycle alloc + wake of entry 0
        step(0, 1, 0,  1, 0, 0, 0, 6'b000001, 0,   1, 1, 1, 2,  1, 0, 5);
        step(0, 1, 0,  0, 0, 0, 0, 6'b000000, 1,   1, 0, 1, 1,  0, 0, 6);
        // entry 1 ready on alloc; wake on non-busy entry 5 dropped
        step(0, 1, 0,  1, 0, 1, 1, 6'b100000, 0,   1, 2, 1, 3,  1, 1, 4);
        step(0, 1, 0,  1, 0, 1, 0, 6'b000000, 0,   1, 4, 1, 5,  1, 1, 2);
        step(0, 1, 0,  1, 1, 0, 0, 6'b000000, 0,   1, 5, 0, 0,  1, 1, 1); // entry 4 ready
        step(0, 1, 0,  0, 0, 0, 0, 6'b000000, 1,   1, 1, 1, 5,  1, 4, 2); // issue 1
        step(0, 0, 0,  1, 1, 1, 1, 6'b111111, 1,   1, 1, 1, 5,  1, 4, 2); // rdy low hold
        step(0, 0, 0,  1, 0, 0, 0, 6'b000000, 1,   1, 1, 1, 5,  1, 4, 2); // rdy low hold
        step(0, 1, 0,  0, 0, 0, 0, 6'b000000, 1,   1, 1, 1, 4,  0, 0, 3); // issue 4
        step(0, 1, 1,  1, 1, 0, 0, 6'b111111, 0,   1, 0, 1, 1,  0, 0, 6); // flush half-full
        step(0, 1, 0,  1, 1, 1, 1, 6'b000000, 0,   1, 2, 1, 3,  1, 0, 4);
        step(1, 0, 0,  1, 1, 1, 1, 6'b000000, 1,   1, 0, 1, 1,  0, 0, 6); // rst over rdy
`ifdef RS_AGE_SELECT_EN
        step(0, 1, 0,  1, 1, 1, 0, 6'b000000, 0,   1, 2, 1, 3,  1, 0, 4); // alloc 0(rdy),1
        step(0, 1, 0,  1, 0, 1, 0, 6'b000000, 1,   1, 0, 1, 4,  0, 0, 3); // alloc 2,3; issue 0
        step(0, 1, 0,  1, 0, 0, 0, 6'b000000, 0,   1, 4, 1, 5,  0, 0, 2); // re-alloc 0 (young)
        step(0, 1, 0,  0, 0, 0, 0, 6'b001001, 0,   1, 4, 1, 5,  1, 3, 2); // wake 0,3 -> 3 oldest
        step(0, 0, 0,  0, 0, 0, 0, 6'b000000, 1,   1, 4, 1, 5,  1, 3, 2); // rdy low hold
        step(0, 0, 0,  0, 0, 0, 0, 6'b000000, 1,   1, 4, 1, 5,  1, 3, 2); // rdy low hold
        step(0, 1, 0,  0, 0, 0, 0, 6'b000000, 1,   1, 3, 1, 4,  1, 0, 3); // issue 3
        step(0, 1, 0,  0, 0, 0, 0, 6'b000000, 1,   1, 0, 1, 3,  0, 0, 4); // issue 0
`endif
        bus.issue_ack = 1'b0; bus.alloc_1 = 1'b0; bus.alloc_2 = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
